// File: rtl/v810_mau_arb.sv
// Arbitrates fetch and data requesters onto one bus-cycle engine. Data wins ties until MAX_DRUN
// consecutive data grants have starved a pending fetch. Grant attributes are registered; ACKs pass BACK through.
module v810_mau_arb #(
  parameter int         MAX_DRUN = 4,
  parameter logic [1:0] FETCH_ST = 2'b11
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] IA,
  input  logic        IREQ,
  output logic        IACK,
  output logic [31:0] ID,
  input  logic [31:0] DA,
  input  logic [31:0] DD_O,
  input  logic [3:0]  DBE,
  input  logic        DWR,
  input  logic [1:0]  DST,
  input  logic        DREQ,
  output logic        DACK,
  output logic [31:0] DD_I,
  output logic [31:0] BA,
  output logic [31:0] BD_O,
  output logic [3:0]  BBE,
  output logic        BWR,
  output logic [1:0]  BST,
  output logic        BREQ,
  input  logic        BACK,
  input  logic [31:0] BD_I,
  output logic [1:0]  GNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_IGNT = 2'b01,
    S_DGNT = 2'b10
  } state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_DRUN);

  state_t      state_q, state_d;
  logic [2:0]  drun_q, drun_d;
  logic [31:0] ba_q, ba_d;
  logic [31:0] bd_q, bd_d;
  logic [3:0]  bbe_q, bbe_d;
  logic        bwr_q, bwr_d;
  logic [1:0]  bst_q, bst_d;
  logic        data_win, fetch_win;

  // Data has priority unless a fetch has already waited through MAX_DRUN data grants.
  assign data_win  = DREQ && (!IREQ || ({1'b0, drun_q} < MAX_W));
  assign fetch_win = IREQ && !data_win;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= S_IDLE;
    end else if (CE) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (data_win) begin
          state_d = S_DGNT;
        end else if (fetch_win) begin
          state_d = S_IGNT;
        end
      end
      S_IGNT, S_DGNT: begin
        if (BACK) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BREQ = (state_q != S_IDLE);
    IACK = (state_q == S_IGNT) && BACK;
    DACK = (state_q == S_DGNT) && BACK;
    ID   = IACK ? BD_I : 32'h0;
    DD_I = DACK ? BD_I : 32'h0;
  end

  // Attributes are sampled only at the grant decision so requester changes mid-cycle are invisible.
  always_comb begin
    drun_d = drun_q;
    ba_d   = ba_q;
    bd_d   = bd_q;
    bbe_d  = bbe_q;
    bwr_d  = bwr_q;
    bst_d  = bst_q;
    if (state_q == S_IDLE) begin
      if (data_win) begin
        ba_d  = DA;
        bd_d  = DD_O;
        bbe_d = DBE;
        bwr_d = DWR;
        bst_d = DST;
        if (IREQ) begin
          drun_d = (drun_q == 3'd7) ? 3'd7 : drun_q + 3'd1;
        end else begin
          drun_d = 3'd0;
        end
      end else if (fetch_win) begin
        ba_d   = IA;
        bd_d   = 32'h0;
        bbe_d  = 4'hF;
        bwr_d  = 1'b0;
        bst_d  = FETCH_ST;
        drun_d = 3'd0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      drun_q <= 3'd0;
      ba_q   <= 32'h0;
      bd_q   <= 32'h0;
      bbe_q  <= 4'h0;
      bwr_q  <= 1'b0;
      bst_q  <= 2'b00;
    end else if (CE) begin
      drun_q <= drun_d;
      ba_q   <= ba_d;
      bd_q   <= bd_d;
      bbe_q  <= bbe_d;
      bwr_q  <= bwr_d;
      bst_q  <= bst_d;
    end
  end

  assign GNT  = state_q;
  assign BA   = ba_q;
  assign BD_O = bd_q;
  assign BBE  = bbe_q;
  assign BWR  = bwr_q;
  assign BST  = bst_q;

endmodule

// File: tb/tb_v810_mau_arb.sv
// Directed scenarios followed by randomized request/engine traffic checked against a transaction-level arbiter model.
module tb_v810_mau_arb;

  logic        CLK, RES, CE;
  logic [31:0] IA, DA, DD_O, BD_I;
  logic        IREQ, DREQ, DWR, BACK;
  logic [3:0]  DBE;
  logic [1:0]  DST;
  logic        IACK, DACK, BWR, BREQ;
  logic [31:0] ID, DD_I, BA, BD_O;
  logic [3:0]  BBE;
  logic [1:0]  BST, GNT;

  int checks = 0;
  int failures = 0;

  v810_mau_arb #(.MAX_DRUN(4), .FETCH_ST(2'b11)) dut (
    .CLK(CLK), .RES(RES), .CE(CE),
    .IA(IA), .IREQ(IREQ), .IACK(IACK), .ID(ID),
    .DA(DA), .DD_O(DD_O), .DBE(DBE), .DWR(DWR), .DST(DST), .DREQ(DREQ),
    .DACK(DACK), .DD_I(DD_I),
    .BA(BA), .BD_O(BD_O), .BBE(BBE), .BWR(BWR), .BST(BST),
    .BREQ(BREQ), .BACK(BACK), .BD_I(BD_I), .GNT(GNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    int          dcnt;
    bit          seen_f;
    int          run;
    bit          i_pend, d_pend, exp_d, last_d, have_last;
    logic [31:0] e_ba, e_bd, rd;
    logic [3:0]  e_be;
    logic        e_wr;
    logic [1:0]  e_st;
    int          waits;

    RES = 1'b1; CE = 1'b1; IA = '0; IREQ = 1'b0; DA = '0; DD_O = '0; DBE = '0;
    DWR = 1'b0; DST = '0; DREQ = 1'b0; BACK = 1'b0; BD_I = '0;

    // Reset state, with requests and BACK active while reset is held.
    #3;
    IREQ = 1'b1; BACK = 1'b1; BD_I = 32'h1111_2222;
    #1;
    chk("rst_gnt", GNT, 2'b00);
    chk("rst_breq", BREQ, 1'b0);
    chk("rst_acks", {IACK, DACK}, 2'b00);
    chk("rst_attrs", {BA ^ BD_O, BBE, BWR, BST}, 39'h0);
    repeat (2) @(posedge CLK);
    #1 chk("rst_hold_gnt", GNT, 2'b00);

    // Fetch only, BACK after two cycles.
    step(); RES = 1'b0; IREQ = 1'b0; BACK = 1'b0; BD_I = '0;
    step(); IA = 32'h8000_0FF0; IREQ = 1'b1; #1;
    chk("f_idle_gnt", GNT, 2'b00);
    step(); #1;
    chk("f_gnt", GNT, 2'b01);
    chk("f_breq", BREQ, 1'b1);
    chk("f_bst", BST, 2'b11);
    chk("f_bbe", BBE, 4'hF);
    chk("f_bwr", BWR, 1'b0);
    chk("f_ba", BA, 32'h8000_0FF0);
    chk("f_bdo", BD_O, 32'h0);
    chk("f_noack", IACK, 1'b0);
    step(); #1;
    chk("f_wait_noack", IACK, 1'b0);
    step(); BACK = 1'b1; BD_I = 32'h8000_BFE0; #1;
    chk("f_iack", IACK, 1'b1);
    chk("f_id", ID, 32'h8000_BFE0);
    chk("f_no_dack", DACK, 1'b0);
    step(); BACK = 1'b0; IREQ = 1'b0; BD_I = '0; #1;
    chk("f_done_gnt", GNT, 2'b00);
    chk("f_done_iack", IACK, 1'b0);
    chk("f_done_id", ID, 32'h0);
    chk("f_hold_ba", BA, 32'h8000_0FF0);

    // Simultaneous requests with a zero-wait engine.
    step(); IREQ = 1'b1; DREQ = 1'b1; DA = 32'h40; BACK = 1'b1; BD_I = 32'h55; #1;
    chk("sim_idle_back_ignored", {IACK, DACK}, 2'b00);
    step(); #1;
    chk("sim_data_first", GNT, 2'b10);
    chk("sim_dack", DACK, 1'b1);
    chk("sim_dd_i", DD_I, 32'h55);
    step(); DREQ = 1'b0; #1;
    chk("sim_gap", {GNT, BREQ}, 3'b000);
    step(); #1;
    chk("sim_fetch_next", GNT, 2'b01);
    chk("sim_iack", IACK, 1'b1);
    step(); IREQ = 1'b0; BACK = 1'b0; #1;
    chk("sim_end", GNT, 2'b00);

    // Starvation bound: DREQ and IREQ both held.
    step(); IREQ = 1'b1; DREQ = 1'b1; BACK = 1'b1;
    dcnt = 0; seen_f = 1'b0;
    for (int i = 0; i < 24 && !seen_f; i++) begin
      step(); #1;
      if (GNT == 2'b10) dcnt++;
      else if (GNT == 2'b01) seen_f = 1'b1;
    end
    chk("starve_dgrants", dcnt, 4);
    chk("starve_fetch_seen", seen_f, 1'b1);
    step(); #1;
    chk("starve_gap", GNT, 2'b00);
    step(); IREQ = 1'b0; DREQ = 1'b0; #1;
    chk("starve_drun_cleared", GNT, 2'b10);
    step(); BACK = 1'b0; #1;
    chk("starve_end", GNT, 2'b00);

    // Write capture, DA changes after grant.
    step(); DA = 32'h70; DD_O = 32'h9; DBE = 4'hF; DWR = 1'b1; DST = 2'b10; DREQ = 1'b1;
    step(); DA = 32'h74; #1;
    chk("w_gnt", GNT, 2'b10);
    chk("w_ba", BA, 32'h70);
    chk("w_bdo", BD_O, 32'h9);
    chk("w_attr", {BBE, BWR, BST}, {4'hF, 1'b1, 2'b10});
    step(); #1;
    chk("w_ba_stable", BA, 32'h70);
    chk("w_wait_noack", DACK, 1'b0);
    step(); BACK = 1'b1; BD_I = 32'hCAFE; #1;
    chk("w_dack", DACK, 1'b1);
    chk("w_ba_at_back", BA, 32'h70);
    step(); BACK = 1'b0; DREQ = 1'b0; BD_I = '0; #1;
    chk("w_dack_once", DACK, 1'b0);
    chk("w_dd_i_zero", DD_I, 32'h0);
    chk("w_ba_hold", BA, 32'h70);

    // Reset during a data grant, requests held.
    step(); DA = 32'h100; DWR = 1'b0; DREQ = 1'b1;
    step(); #1;
    chk("r_gnt", GNT, 2'b10);
    #2 RES = 1'b1; #1;
    chk("r_breq_drop", BREQ, 1'b0);
    chk("r_gnt_idle", GNT, 2'b00);
    chk("r_no_dack", DACK, 1'b0);
    chk("r_ba_clr", BA, 32'h0);
    step(); RES = 1'b0; #1;
    chk("r_released_idle", GNT, 2'b00);
    step(); #1;
    chk("r_regrant", GNT, 2'b10);
    chk("r_regrant_ba", BA, 32'h100);
    step(); BACK = 1'b1; #1;
    chk("r_dack", DACK, 1'b1);
    step(); BACK = 1'b0; DREQ = 1'b0; #1;
    chk("r_end", GNT, 2'b00);

    // Clock-enable gating around a one-wait data cycle.
    step(); CE = 1'b0; DA = 32'h200; DREQ = 1'b1; #1;
    chk("ce_idle", GNT, 2'b00);
    step(); CE = 1'b1; #1;
    chk("ce_no_grant_when_low", GNT, 2'b00);
    step(); CE = 1'b0; #1;
    chk("ce_grant", GNT, 2'b10);
    chk("ce_wait_noack", DACK, 1'b0);
    step(); BACK = 1'b1; #1;
    chk("ce_comb_dack", DACK, 1'b1);
    step(); CE = 1'b1; #1;
    chk("ce_not_consumed", GNT, 2'b10);
    step(); CE = 1'b0; BACK = 1'b0; DREQ = 1'b0; #1;
    chk("ce_consumed", GNT, 2'b00);
    chk("ce_no_dup_ack", DACK, 1'b0);
    step(); CE = 1'b1; #1;
    chk("ce_end", {GNT, BREQ, DACK}, 4'b0000);

    // Random traffic; the last grant was data with IREQ=0, so the starvation count is zero.
    run = 0; i_pend = 1'b0; d_pend = 1'b0; have_last = 1'b0; last_d = 1'b0;
    for (int it = 0; it < 160; it++) begin
      step();
      if (have_last) begin
        if (last_d) d_pend = 1'b0; else i_pend = 1'b0;
        have_last = 1'b0;
      end
      if (!i_pend && ($urandom_range(1, 0) == 1)) begin
        i_pend = 1'b1; IA = $urandom();
      end
      if (!d_pend && ($urandom_range(2, 0) != 0)) begin
        d_pend = 1'b1; DA = $urandom(); DD_O = $urandom();
        DBE = 4'($urandom()); DWR = 1'($urandom()); DST = 2'($urandom());
      end
      IREQ = i_pend; DREQ = d_pend;
      BACK = 1'($urandom()); BD_I = $urandom();
      #1;
      chk("rnd_idle_gnt", GNT, 2'b00);
      chk("rnd_idle_noack", {IACK, DACK}, 2'b00);
      if (!i_pend && !d_pend) continue;

      exp_d = d_pend && (!i_pend || run < 4);
      if (exp_d) begin
        run = i_pend ? ((run < 7) ? run + 1 : 7) : 0;
        e_ba = DA; e_bd = DD_O; e_be = DBE; e_wr = DWR; e_st = DST;
      end else begin
        run = 0;
        e_ba = IA; e_bd = 32'h0; e_be = 4'hF; e_wr = 1'b0; e_st = 2'b11;
      end

      step(); BACK = 1'b0;
      if (exp_d && ($urandom_range(1, 0) == 1)) begin
        DA = $urandom(); DD_O = $urandom(); DBE = 4'($urandom());
      end
      #1;
      chk("rnd_gnt", GNT, exp_d ? 2'b10 : 2'b01);
      chk("rnd_breq", BREQ, 1'b1);
      chk("rnd_ba", BA, e_ba);
      chk("rnd_bdo", BD_O, e_bd);
      chk("rnd_attr", {BBE, BWR, BST}, {e_be, e_wr, e_st});
      waits = $urandom_range(2, 0);
      for (int w = 0; w < waits; w++) begin
        step(); #1;
        chk("rnd_wait_noack", {IACK, DACK}, 2'b00);
      end
      step(); BACK = 1'b1; rd = $urandom(); BD_I = rd; #1;
      chk("rnd_acks", {IACK, DACK}, exp_d ? 2'b01 : 2'b10);
      chk("rnd_rdata", exp_d ? DD_I : ID, rd);
      chk("rnd_other_zero", exp_d ? ID : DD_I, 32'h0);
      chk("rnd_ba_at_back", BA, e_ba);
      last_d = exp_d; have_last = 1'b1;
    end
    step(); BACK = 1'b0; IREQ = 1'b0; DREQ = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
